// File: rtl/lsu_split_pkg.sv
// Shared load/store pipeline definitions: memory op encodings, LSU FSM states
// and the access-size helper used when a request is latched.
package lsu_split_pkg;

    typedef enum logic [2:0] {
        LD_NONE, LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LW, LD_LWU, LD_LD
    } type_ld_ops_e;

    typedef enum logic [2:0] {
        ST_NONE, ST_SB, ST_SH, ST_SW, ST_SD
    } type_st_ops_e;

    typedef enum logic [1:0] {
        LSU_IDLE, LSU_BEAT0, LSU_BEAT1, LSU_RESP
    } lsu_state_e;

    // Access size in bytes; callers guarantee at most one op is non-NONE.
    function automatic logic [3:0] op_size(input type_ld_ops_e ld, input type_st_ops_e st);
        logic [3:0] sz;
        case (ld)
            LD_LB, LD_LBU: sz = 4'd1;
            LD_LH, LD_LHU: sz = 4'd2;
            LD_LW, LD_LWU: sz = 4'd4;
            LD_LD:         sz = 4'd8;
            default: begin
                case (st)
                    ST_SB:   sz = 4'd1;
                    ST_SH:   sz = 4'd2;
                    ST_SW:   sz = 4'd4;
                    ST_SD:   sz = 4'd8;
                    default: sz = 4'd0;
                endcase
            end
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/lsu_split_lane_align.sv
// Byte-lane steering for the LSU: byte enables and store data for the current
// beat, and reassembly plus sign/zero extension of load data from both beats.
module lsu_lane_align
    import lsu_split_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NLANE  = DATA_W / 8,
    localparam int OFS_W  = $clog2(NLANE)
) (
    input  logic [OFS_W-1:0]  ofs_i,
    input  logic [3:0]        size_i,
    input  logic              beat1_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  type_ld_ops_e      ld_op_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic [DATA_W-1:0] hi_i,
    output logic [NLANE-1:0]  be_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [2*NLANE-1:0]  mask_w;
    logic [2*DATA_W-1:0] wide_w;
    logic [DATA_W-1:0]   raw_w;

    // Keep the low nbits of v; fill above with the top kept bit when sgn is set.
    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                                 input logic [6:0] nbits, input logic sgn);
        logic [DATA_W-1:0] m;
        logic              top;
        m   = (nbits >= 7'(DATA_W)) ? '1 : ((DATA_W'(1) << nbits) - DATA_W'(1));
        top = |(v & (m ^ (m >> 1)));
        return (v & m) | ((sgn && top) ? ~m : '0);
    endfunction

    // Work in a double-width window: low half is beat 0, high half is beat 1.
    always_comb begin
        mask_w  = ((2*NLANE)'(1) << size_i) - (2*NLANE)'(1);
        mask_w  = mask_w << ofs_i;
        wide_w  = {{DATA_W{1'b0}}, wdata_i} << {ofs_i, 3'b000};
        be_o    = beat1_i ? mask_w[2*NLANE-1:NLANE] : mask_w[NLANE-1:0];
        wdata_o = beat1_i ? wide_w[2*DATA_W-1:DATA_W] : wide_w[DATA_W-1:0];
        raw_w   = DATA_W'({hi_i, lo_i} >> {ofs_i, 3'b000});
        case (ld_op_i)
            LD_LB:   rdata_o = extend(raw_w, 7'd8,  1'b1);
            LD_LBU:  rdata_o = extend(raw_w, 7'd8,  1'b0);
            LD_LH:   rdata_o = extend(raw_w, 7'd16, 1'b1);
            LD_LHU:  rdata_o = extend(raw_w, 7'd16, 1'b0);
            LD_LW:   rdata_o = extend(raw_w, 7'd32, 1'b1);
            LD_LWU:  rdata_o = extend(raw_w, 7'd32, 1'b0);
            LD_LD:   rdata_o = raw_w;
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_split.sv
// Load/store unit front end: accepts one EXE memory op, issues one or two
// lane-aligned data-bus beats (splitting misaligned accesses), and responds.
module lsu_split
    import lsu_split_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 32,
    localparam int NLANE  = DATA_W / 8,
    localparam int OFS_W  = $clog2(NLANE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  type_ld_ops_e      ld_ops_i,
    input  type_st_ops_e      st_ops_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              flush_i,
    output logic              dbus_req_o,
    output logic              dbus_we_o,
    output logic [ADDR_W-1:0] dbus_addr_o,
    output logic [NLANE-1:0]  dbus_be_o,
    output logic [DATA_W-1:0] dbus_wdata_o,
    input  logic              dbus_ack_i,
    input  logic [DATA_W-1:0] dbus_rdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic [4:0]        rsp_rd_addr_o,
    output logic              stall_o,
    output logic              err_o
);

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
        $error("lsu_split: DATA_W must be 32 or 64");
    end

    lsu_state_e        state_q, state_d;
    type_ld_ops_e      ld_q;
    type_st_ops_e      st_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, lo_q, hi_q;
    logic [4:0]        rd_q;
    logic [3:0]        size_q;
    logic              flushed_q, err_q;

    logic              ld_any, st_any, illegal, accept;
    logic              is_load, in_beat, split, flush_ld;
    logic [OFS_W-1:0]  ofs;
    logic [ADDR_W-1:0] base;
    logic [NLANE-1:0]  be_w;
    logic [DATA_W-1:0] wdata_w, rdata_w;

    assign ld_any  = (ld_ops_i != LD_NONE);
    assign st_any  = (st_ops_i != ST_NONE);
    assign illegal = (ld_any && st_any) ||
                     (DATA_W == 32 && (ld_ops_i == LD_LWU || ld_ops_i == LD_LD || st_ops_i == ST_SD));
    assign accept  = (state_q == LSU_IDLE) && req_valid_i && !flush_i && (ld_any ^ st_any) && !illegal;

    assign is_load  = (ld_q != LD_NONE);
    assign in_beat  = (state_q == LSU_BEAT0) || (state_q == LSU_BEAT1);
    assign ofs      = addr_q[OFS_W-1:0];
    assign split    = (5'(ofs) + 5'(size_q)) > 5'(NLANE);
    assign base     = addr_q & ~ADDR_W'(NLANE - 1);
    // A load flush seen in any beat cycle, including the ack cycle, kills it.
    assign flush_ld = is_load && (flushed_q || flush_i);

    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .ofs_i   (ofs),
        .size_i  (size_q),
        .beat1_i (state_q == LSU_BEAT1),
        .wdata_i (wdata_q),
        .ld_op_i (ld_q),
        .lo_i    (lo_q),
        .hi_i    (hi_q),
        .be_o    (be_w),
        .wdata_o (wdata_w),
        .rdata_o (rdata_w)
    );

    always_comb begin
        state_d       = state_q;
        req_ready_o   = (state_q == LSU_IDLE);
        stall_o       = (state_q != LSU_IDLE) || accept;
        dbus_req_o    = 1'b0;
        dbus_we_o     = 1'b0;
        dbus_addr_o   = '0;
        dbus_be_o     = '0;
        dbus_wdata_o  = '0;
        rsp_valid_o   = 1'b0;
        rsp_rdata_o   = '0;
        rsp_rd_addr_o = '0;
        case (state_q)
            LSU_IDLE:  if (accept) state_d = LSU_BEAT0;
            LSU_BEAT0: if (dbus_ack_i) state_d = flush_ld ? LSU_IDLE : (split ? LSU_BEAT1 : LSU_RESP);
            LSU_BEAT1: if (dbus_ack_i) state_d = flush_ld ? LSU_IDLE : LSU_RESP;
            LSU_RESP:  state_d = LSU_IDLE;
            default:   state_d = LSU_IDLE;
        endcase
        // Bus outputs derive only from latched state, so they hold steady until ack.
        if (in_beat) begin
            dbus_req_o   = 1'b1;
            dbus_we_o    = !is_load;
            dbus_addr_o  = (state_q == LSU_BEAT1) ? base + ADDR_W'(NLANE) : base;
            dbus_be_o    = be_w;
            dbus_wdata_o = is_load ? '0 : wdata_w;
        end
        if (state_q == LSU_RESP) begin
            rsp_valid_o   = !(is_load && flush_i);
            rsp_rd_addr_o = rd_q;
            rsp_rdata_o   = is_load ? rdata_w : '0;
        end
    end

    assign err_o = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LSU_IDLE;
            ld_q      <= LD_NONE;
            st_q      <= ST_NONE;
            addr_q    <= '0;
            wdata_q   <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            rd_q      <= '0;
            size_q    <= '0;
            flushed_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == LSU_IDLE) && req_valid_i && !flush_i && illegal;
            if (accept) begin
                ld_q      <= ld_ops_i;
                st_q      <= st_ops_i;
                addr_q    <= addr_i;
                wdata_q   <= wdata_i;
                rd_q      <= rd_addr_i;
                size_q    <= op_size(ld_ops_i, st_ops_i);
                flushed_q <= 1'b0;
            end else if (in_beat && flush_i) begin
                flushed_q <= 1'b1;
            end
            if (state_q == LSU_BEAT0 && dbus_ack_i) lo_q <= dbus_rdata_i;
            if (state_q == LSU_BEAT1 && dbus_ack_i) hi_q <= dbus_rdata_i;
        end
    end

endmodule

// File: tb/tb_lsu_split.sv
// Bench for lsu_split: drives a 32-bit and a 64-bit instance and checks them
// against a byte-level memory/transaction model.
module tb_lsu_split;
    import lsu_split_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         sel = 1'b0;
    logic         req_v = 1'b0, ack = 1'b0, flush = 1'b0;
    type_ld_ops_e ld = LD_NONE;
    type_st_ops_e st = ST_NONE;
    logic [31:0]  addr = '0;
    logic [63:0]  wdata = '0, rdata = '0;
    logic [4:0]   rd = '0;

    logic        r32_ready, r32_dreq, r32_we, r32_rsp, r32_stall, r32_err;
    logic [31:0] r32_addr, r32_wd, r32_rdata;
    logic [3:0]  r32_be;
    logic [4:0]  r32_rd;
    logic        r64_ready, r64_dreq, r64_we, r64_rsp, r64_stall, r64_err;
    logic [31:0] r64_addr;
    logic [63:0] r64_wd, r64_rdata;
    logic [7:0]  r64_be;
    logic [4:0]  r64_rd;

    lsu_split #(.DATA_W(32), .ADDR_W(32)) u32 (
        .clk(clk), .rst(rst), .req_valid_i(req_v & ~sel), .req_ready_o(r32_ready),
        .ld_ops_i(ld), .st_ops_i(st), .addr_i(addr), .wdata_i(wdata[31:0]), .rd_addr_i(rd),
        .flush_i(flush), .dbus_req_o(r32_dreq), .dbus_we_o(r32_we), .dbus_addr_o(r32_addr),
        .dbus_be_o(r32_be), .dbus_wdata_o(r32_wd), .dbus_ack_i(ack & ~sel),
        .dbus_rdata_i(rdata[31:0]), .rsp_valid_o(r32_rsp), .rsp_rdata_o(r32_rdata),
        .rsp_rd_addr_o(r32_rd), .stall_o(r32_stall), .err_o(r32_err)
    );

    lsu_split #(.DATA_W(64), .ADDR_W(32)) u64 (
        .clk(clk), .rst(rst), .req_valid_i(req_v & sel), .req_ready_o(r64_ready),
        .ld_ops_i(ld), .st_ops_i(st), .addr_i(addr), .wdata_i(wdata), .rd_addr_i(rd),
        .flush_i(flush), .dbus_req_o(r64_dreq), .dbus_we_o(r64_we), .dbus_addr_o(r64_addr),
        .dbus_be_o(r64_be), .dbus_wdata_o(r64_wd), .dbus_ack_i(ack & sel),
        .dbus_rdata_i(rdata), .rsp_valid_o(r64_rsp), .rsp_rdata_o(r64_rdata),
        .rsp_rd_addr_o(r64_rd), .stall_o(r64_stall), .err_o(r64_err)
    );

    logic        o_ready, o_dreq, o_we, o_rsp, o_stall, o_err;
    logic [31:0] o_addr;
    logic [7:0]  o_be;
    logic [63:0] o_wd, o_rdata;
    logic [4:0]  o_rd;
    assign o_ready = sel ? r64_ready : r32_ready;
    assign o_dreq  = sel ? r64_dreq  : r32_dreq;
    assign o_we    = sel ? r64_we    : r32_we;
    assign o_rsp   = sel ? r64_rsp   : r32_rsp;
    assign o_stall = sel ? r64_stall : r32_stall;
    assign o_err   = sel ? r64_err   : r32_err;
    assign o_addr  = sel ? r64_addr  : r32_addr;
    assign o_be    = sel ? r64_be    : {4'b0, r32_be};
    assign o_wd    = sel ? r64_wd    : {32'b0, r32_wd};
    assign o_rdata = sel ? r64_rdata : {32'b0, r32_rdata};
    assign o_rd    = sel ? r64_rd    : r32_rd;

    int n_chk  = 0;
    int n_fail = 0;

    // Sparse byte memory; unwritten addresses read a fixed address hash.
    logic [7:0] mem [logic [31:0]];

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'(a * 32'd29 + (a >> 11) + 32'd60);
    endfunction

    function automatic int size_of(input type_ld_ops_e l, input type_st_ops_e t);
        case (l)
            LD_LB, LD_LBU: return 1;
            LD_LH, LD_LHU: return 2;
            LD_LW, LD_LWU: return 4;
            LD_LD:         return 8;
            default: ;
        endcase
        case (t)
            ST_SB: return 1;
            ST_SH: return 2;
            ST_SW: return 4;
            ST_SD: return 8;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction. Expected beats come from walking the accessed
    // byte addresses and grouping them by aligned bus word.
    task automatic run_txn(input logic s, input type_ld_ops_e l, input type_st_ops_e t,
                           input logic [31:0] a, input logic [63:0] wd, input logic [4:0] r,
                           input int waitc, input bit fl_beat, input bit fl_resp);
        int          nl, sz, nb, off;
        bit          is_ld, sgn;
        logic [31:0] base0, base, ba, amask;
        logic [63:0] exp_ld, exp_wd, lm, beat_rd, dmask;
        logic [7:0]  exp_be;
        nl     = s ? 8 : 4;
        sz     = size_of(l, t);
        is_ld  = (l != LD_NONE);
        sgn    = (l == LD_LB || l == LD_LH || l == LD_LW);
        dmask  = s ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        amask  = ~32'(nl - 1);
        base0  = a & amask;
        nb     = (((a + 32'(sz - 1)) & amask) != base0) ? 2 : 1;
        exp_ld = '0;
        for (int k = 0; k < sz; k++) exp_ld[8*k +: 8] = mem_byte(a + 32'(k));
        if (sgn && exp_ld[8*sz-1]) for (int k = sz; k < 8; k++) exp_ld[8*k +: 8] = 8'hFF;
        exp_ld = exp_ld & dmask;

        @(negedge clk);
        sel = s; req_v = 1'b1; ld = l; st = t; addr = a; wdata = wd; rd = r;
        #1;
        chk("acc_ready", o_ready, 1);
        chk("acc_stall", o_stall, 1);
        @(negedge clk);
        req_v = 1'b0; ld = LD_NONE; st = ST_NONE;
        for (int b = 0; b < nb; b++) begin
            base    = base0 + 32'(b * nl);
            exp_be  = '0;
            exp_wd  = '0;
            lm      = '0;
            beat_rd = '0;
            for (int k = 0; k < sz; k++) begin
                ba = a + 32'(k);
                if ((ba & amask) == base) begin
                    off = int'(ba - base);
                    exp_be[off] = 1'b1;
                    exp_wd[8*off +: 8] = wd[8*k +: 8];
                    lm[8*off +: 8] = 8'hFF;
                end
            end
            for (int j = 0; j < nl; j++) beat_rd[8*j +: 8] = mem_byte(base + 32'(j));
            for (int w = 0; w < waitc; w++) begin
                #1;
                chk("wait_req", o_dreq, 1);
                chk("wait_addr", o_addr, base);
                @(negedge clk);
            end
            #1;
            chk("beat_req", o_dreq, 1);
            chk("beat_we", o_we, !is_ld);
            chk("beat_addr", o_addr, base);
            chk("beat_be", o_be, exp_be);
            if (!is_ld) chk("beat_wdata", o_wd & lm, exp_wd);
            if (fl_beat && b == 0) flush = 1'b1;
            ack = 1'b1; rdata = beat_rd;
            @(negedge clk);
            ack = 1'b0; flush = 1'b0;
        end
        #1;
        chk("rsp_noreq", o_dreq, 0);
        if (fl_resp) begin
            flush = 1'b1;
            #1;
            chk("rsp_flushed", o_rsp, 0);
            flush = 1'b0;
        end else begin
            chk("rsp_valid", o_rsp, 1);
            chk("rsp_rd", o_rd, r);
            chk("rsp_rdata", o_rdata, is_ld ? exp_ld : 64'd0);
        end
        @(negedge clk);
        #1;
        chk("post_rsp", o_rsp, 0);
        chk("post_ready", o_ready, 1);
    endtask

    initial begin
        logic              s;
        type_ld_ops_e      l;
        type_st_ops_e      t;
        logic [31:0]       a;

        // Reset state on both widths.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            sel = 1'(i);
            #1;
            chk("rst_ready", o_ready, 1);
            chk("rst_dreq", o_dreq, 0);
            chk("rst_rsp", o_rsp, 0);
            chk("rst_err", o_err, 0);
            chk("rst_stall", o_stall, 0);
            chk("rst_be", o_be, 0);
        end
        rst = 1'b0;

        // Aligned word, zero-wait bus.
        mem[32'h100] = 8'hEF; mem[32'h101] = 8'hBE; mem[32'h102] = 8'hAD; mem[32'h103] = 8'hDE;
        run_txn(1'b0, LD_LW, ST_NONE, 32'h100, 64'd0, 5'd5, 0, 1'b0, 1'b0);
        // Split halfword across a word boundary.
        mem[32'h103] = 8'h80; mem[32'h104] = 8'h7F;
        run_txn(1'b0, LD_LH, ST_NONE, 32'h103, 64'd0, 5'd6, 0, 1'b0, 1'b0);
        // Split doubleword store on the 64-bit bus.
        run_txn(1'b1, LD_NONE, ST_SD, 32'h1004, 64'h1122334455667788, 5'd9, 1, 1'b0, 1'b0);
        // Top of address space: single beat, then wrapping split.
        run_txn(1'b0, LD_LB, ST_NONE, 32'hFFFF_FFFF, 64'd0, 5'd1, 0, 1'b0, 1'b0);
        run_txn(1'b0, LD_NONE, ST_SW, 32'hFFFF_FFFE, 64'hCAFEF00D, 5'd2, 2, 1'b0, 1'b0);
        // Store flushed mid-beat still completes; load flushed in RESP is silent.
        run_txn(1'b0, LD_NONE, ST_SH, 32'h207, 64'hABCD, 5'd3, 1, 1'b1, 1'b0);
        run_txn(1'b1, LD_LW, ST_NONE, 32'h2006, 64'd0, 5'd4, 0, 1'b0, 1'b1);

        // Flush in IDLE blocks acceptance.
        @(negedge clk);
        sel = 1'b0; req_v = 1'b1; ld = LD_LW; addr = 32'h200; flush = 1'b1;
        #1;
        chk("idle_flush_stall", o_stall, 0);
        @(negedge clk);
        req_v = 1'b0; ld = LD_NONE; flush = 1'b0;
        #1;
        chk("idle_flush_noreq", o_dreq, 0);
        chk("idle_flush_ready", o_ready, 1);

        // Split load flushed in BEAT0, acked three cycles after the beat starts.
        @(negedge clk);
        sel = 1'b0; req_v = 1'b1; ld = LD_LH; addr = 32'h103; rd = 5'd7;
        @(negedge clk);
        req_v = 1'b0; ld = LD_NONE; flush = 1'b1;
        #1;
        chk("fl_req0", o_dreq, 1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fl_req1", o_dreq, 1);
        @(negedge clk);
        #1;
        chk("fl_req2", o_dreq, 1);
        ack = 1'b1; rdata = 64'h0000_0000_8000_0000;
        @(negedge clk);
        ack = 1'b0;
        #1;
        chk("fl_after_req", o_dreq, 0);
        chk("fl_after_rsp", o_rsp, 0);
        chk("fl_after_ready", o_ready, 1);
        @(negedge clk);
        #1;
        chk("fl_late_rsp", o_rsp, 0);
        chk("fl_late_req", o_dreq, 0);

        // LD on the 32-bit bus is rejected with a one-cycle error.
        @(negedge clk);
        sel = 1'b0; req_v = 1'b1; ld = LD_LD; addr = 32'h300;
        #1;
        chk("err_stall", o_stall, 0);
        @(negedge clk);
        req_v = 1'b0; ld = LD_NONE;
        #1;
        chk("err_pulse", o_err, 1);
        chk("err_noreq", o_dreq, 0);
        @(negedge clk);
        #1;
        chk("err_gone", o_err, 0);
        chk("err_noreq2", o_dreq, 0);

        // Reset in BEAT1 abandons the transaction at once.
        @(negedge clk);
        sel = 1'b0; req_v = 1'b1; st = ST_SW; addr = 32'hFFFF_FFFE; wdata = 64'h12345678;
        @(negedge clk);
        req_v = 1'b0; st = ST_NONE;
        #1;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        #1;
        chk("b1_req", o_dreq, 1);
        chk("b1_addr", o_addr, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("b1_rst_req", o_dreq, 0);
        chk("b1_rst_ready", o_ready, 1);
        chk("b1_rst_rsp", o_rsp, 0);

        // Random legal transactions on both widths.
        for (int i = 0; i < 80; i++) begin
            s = 1'($urandom_range(0, 1));
            l = LD_NONE;
            t = ST_NONE;
            if ($urandom_range(0, 1) == 1) l = type_ld_ops_e'(3'($urandom_range(1, s ? 7 : 5)));
            else                           t = type_st_ops_e'(3'($urandom_range(1, s ? 4 : 3)));
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0 | (a & 32'hF);
            run_txn(s, l, t, a, {$urandom, $urandom}, 5'($urandom), int'($urandom_range(0, 2)),
                    (t != ST_NONE) && ($urandom_range(0, 3) == 0),
                    (l != LD_NONE) && ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_split.md
LSU_SPLIT -- requirements
Module: lsu_split

Interface
REQ-001 Parameter DATA_W, default 32, data bus width in bits; SHALL accept only 32 or 64.
REQ-002 Parameter ADDR_W, default 32, byte address width.
REQ-003 Derived constant NLANE = DATA_W/8 byte lanes; OFS_W = log2(NLANE).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid_i  in  1  EXE has a load/store this cycle.
REQ-007 req_ready_o  out  1  block can accept a request.
REQ-008 ld_ops_i  in  type_ld_ops_e  NONE/LB/LBU/LH/LHU/LW/LWU/LD.
REQ-009 st_ops_i  in  type_st_ops_e  NONE/SB/SH/SW/SD.
REQ-010 addr_i  in  ADDR_W  byte address (ALU result).
REQ-011 wdata_i  in  DATA_W  store data, right-aligned.
REQ-012 rd_addr_i  in  5  destination register tag.
REQ-013 flush_i  in  1  pipeline flush from CSR.
REQ-014 dbus_req_o  out  1; dbus_we_o  out  1; dbus_addr_o  out  ADDR_W (lane-aligned); dbus_be_o  out  NLANE; dbus_wdata_o  out  DATA_W (lane-positioned).
REQ-015 dbus_ack_i  in  1; dbus_rdata_i  in  DATA_W  valid when ack.
REQ-016 rsp_valid_o  out  1; rsp_rdata_o  out  DATA_W (sign/zero-extended); rsp_rd_addr_o  out  5; stall_o  out  1; err_o  out  1.

Function
REQ-017 FSM states IDLE, BEAT0, BEAT1, RESP; req_ready_o = (state==IDLE); stall_o = !req_ready_o | (req_valid_i & IDLE-accept cycle).
REQ-018 Accept when IDLE & req_valid_i & exactly one of ld/st op non-NONE; latch op, addr, wdata, rd_addr; go BEAT0.
REQ-019 Both ops non-NONE, or LWU/LD/SD with DATA_W=32: no bus access, err_o pulses 1 cycle, stay IDLE.
REQ-020 size = 1/2/4/8 bytes; ofs = addr[OFS_W-1:0]; split = (ofs + size > NLANE).
REQ-021 BEAT0: addr = addr & ~(NLANE-1); be = size-mask << ofs truncated to NLANE; wdata shifted left by 8*ofs.
REQ-022 BEAT1 (split only): addr = BEAT0 addr + NLANE (wraps modulo 2^ADDR_W); be = remaining low lanes; wdata = bytes not sent in BEAT0, starting lane 0.
REQ-023 dbus_req_o high and all dbus outputs stable from entry into a BEAT state until the cycle dbus_ack_i is seen; dbus_req_o drops the cycle after ack.
REQ-024 Ack in BEAT0: split -> BEAT1, else -> RESP; ack in BEAT1 -> RESP; ack in IDLE/RESP ignored.
REQ-025 Loads: BEAT0 lanes captured into hold register; BEAT1 lanes merged above them; result shifted right by 8*ofs, then extended per op.
REQ-026 RESP: rsp_valid_o = 1 for exactly one cycle (loads and stores), rsp_rd_addr_o = latched rd_addr; next state IDLE; rsp_rdata_o = 0 for stores.
REQ-027 Minimum latency: accept cycle + ack cycle + RESP = response 1 cycle after ack for zero-wait bus.
REQ-028 flush_i in IDLE: request that cycle not accepted.
REQ-029 flush_i during a load beat: outstanding beat still held until ack; then IDLE, no BEAT1, no rsp_valid_o.
REQ-030 flush_i during a store: ignored; store completes all beats and responds.
REQ-031 flush_i in RESP: rsp_valid_o suppressed for loads.

Reset
REQ-032 rst SHALL force state IDLE, clear hold/latched registers; all outputs 0 except req_ready_o = 1.
REQ-033 rst mid-transaction abandons beats immediately; dbus_req_o = 0 next cycle.

Structure
REQ-034 type_ld_ops_e, type_st_ops_e (extended with LWU/LD/SD) and lsu FSM state enum belong in the shared pipeline defs package.
REQ-035 One sub-module lsu_lane_align: combinational be/wdata shift and rdata merge/extend, parametrised by DATA_W.

Verification
REQ-036 DATA_W=32, LW addr 0x100, ack next cycle, rdata 0xDEADBEEF -> one beat be=1111, rsp 0xDEADBEEF 1 cycle after ack.
REQ-037 DATA_W=32, LH addr 0x103, beat0 rdata 0x80xxxxxx, beat1 rdata 0xxxxxxx7F -> beats at 0x100 be=1000, 0x104 be=0001; rsp 0x00007F80.
REQ-038 DATA_W=64, SD addr 0x1004 data 0x1122334455667788 -> beat0 0x1000 be=0xF0 wdata upper=0x55667788; beat1 0x1008 be=0x0F wdata lower=0x11223344.
REQ-039 DATA_W=32, LB addr 0xFFFFFFFF -> single beat 0xFFFFFFFC be=1000; SW addr 0xFFFFFFFE -> beat1 wraps to 0x00000000.
REQ-040 Split load with flush_i asserted during BEAT0 and ack 3 cycles later -> dbus_req_o held 3 cycles, no BEAT1, no rsp_valid_o, IDLE after ack.
REQ-041 LD with DATA_W=32 -> err_o 1-cycle pulse, dbus_req_o stays 0; rst asserted in BEAT1 -> dbus_req_o 0 next cycle, req_ready_o 1.
